// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and the per-axis region state encoding.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_AREA_DEF = 640;
  localparam int H_FRONT_PORCH_DEF  = 16;
  localparam int H_SYNC_PULSE_DEF   = 96;
  localparam int H_BACK_PORCH_DEF   = 48;
  localparam int H_TOTAL = H_VISIBLE_AREA_DEF + H_FRONT_PORCH_DEF + H_SYNC_PULSE_DEF + H_BACK_PORCH_DEF;

  localparam int V_VISIBLE_AREA_DEF = 480;
  localparam int V_FRONT_PORCH_DEF  = 10;
  localparam int V_SYNC_PULSE_DEF   = 2;
  localparam int V_BACK_PORCH_DEF   = 33;
  localparam int V_TOTAL = V_VISIBLE_AREA_DEF + V_FRONT_PORCH_DEF + V_SYNC_PULSE_DEF + V_BACK_PORCH_DEF;

  localparam int SYNC_DELAY_DEF = 2;

  typedef enum logic [1:0] {
    S_VISIBLE,
    S_FRONT_PORCH,
    S_SYNC,
    S_BACK_PORCH
  } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter, region FSM and registered active-low sync.
// state_next exposes the region being entered so the top can register flags aligned with count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE     = H_VISIBLE_AREA_DEF,
  parameter int FRONT_PORCH = H_FRONT_PORCH_DEF,
  parameter int SYNC_PULSE  = H_SYNC_PULSE_DEF,
  parameter int BACK_PORCH  = H_BACK_PORCH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output axis_state_t      state_next,
  output logic             sync_n,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(VISIBLE + FRONT_PORCH + SYNC_PULSE + BACK_PORCH - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT_PORCH);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(VISIBLE + FRONT_PORCH + SYNC_PULSE);

  axis_state_t      state;
  logic [CNT_W-1:0] count_next;

  // wrap is combinational so the V axis can advance on the same edge H wraps.
  assign wrap = advance && (count == LAST);

  always_comb begin
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (advance) begin
      count_next = count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_VISIBLE:     if (count_next == FP_START)   state_next = S_FRONT_PORCH;
      S_FRONT_PORCH: if (count_next == SYNC_START) state_next = S_SYNC;
      S_SYNC:        if (count_next == BP_START)   state_next = S_BACK_PORCH;
      S_BACK_PORCH:  if (count_next == '0)         state_next = S_VISIBLE;
      default:                                     state_next = S_VISIBLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      state  <= S_VISIBLE;
      sync_n <= 1'b1;
    end else begin
      count  <= count_next;
      state  <= state_next;
      sync_n <= (state_next != S_SYNC);
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// 640x480@60 VGA raster generator: H/V counters, active-low syncs, visible flag, line/frame strobes.
// VGA_SYNC_DELAY_EN adds a SYNC_DELAY-deep delay line on HSync/VSync only.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE_AREA = H_VISIBLE_AREA_DEF,
  parameter int H_FRONT_PORCH  = H_FRONT_PORCH_DEF,
  parameter int H_SYNC_PULSE   = H_SYNC_PULSE_DEF,
  parameter int H_BACK_PORCH   = H_BACK_PORCH_DEF,
  parameter int V_VISIBLE_AREA = V_VISIBLE_AREA_DEF,
  parameter int V_FRONT_PORCH  = V_FRONT_PORCH_DEF,
  parameter int V_SYNC_PULSE   = V_SYNC_PULSE_DEF,
  parameter int V_BACK_PORCH   = V_BACK_PORCH_DEF
`ifdef VGA_SYNC_DELAY_EN
  , parameter int SYNC_DELAY   = SYNC_DELAY_DEF
`endif
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  output logic [CNT_W-1:0] o_H_Counter,
  output logic [CNT_W-1:0] o_V_Counter,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Visible,
  output logic             o_Line_Start,
  output logic             o_Frame_Start
);

  axis_state_t h_state_next, v_state_next;
  logic        h_sync_n, v_sync_n;
  logic        h_wrap, v_wrap;

  vga_axis_counter #(
    .VISIBLE     (H_VISIBLE_AREA),
    .FRONT_PORCH (H_FRONT_PORCH),
    .SYNC_PULSE  (H_SYNC_PULSE),
    .BACK_PORCH  (H_BACK_PORCH)
  ) u_h_axis (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .advance    (1'b1),
    .count      (o_H_Counter),
    .state_next (h_state_next),
    .sync_n     (h_sync_n),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE     (V_VISIBLE_AREA),
    .FRONT_PORCH (V_FRONT_PORCH),
    .SYNC_PULSE  (V_SYNC_PULSE),
    .BACK_PORCH  (V_BACK_PORCH)
  ) u_v_axis (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .advance    (h_wrap),
    .count      (o_V_Counter),
    .state_next (v_state_next),
    .sync_n     (v_sync_n),
    .wrap       (v_wrap)
  );

  // v_wrap already implies h_wrap, so it marks the (last,last) -> (0,0) edge.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Visible     <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Visible     <= (h_state_next == S_VISIBLE) && (v_state_next == S_VISIBLE);
      o_Line_Start  <= h_wrap;
      o_Frame_Start <= v_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] h_dly, v_dly;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      h_dly <= '1;
      v_dly <= '1;
    end else begin
      h_dly[0] <= h_sync_n;
      v_dly[0] <= v_sync_n;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        h_dly[i] <= h_dly[i-1];
        v_dly[i] <= v_dly[i-1];
      end
    end
  end

  assign o_HSync = h_dly[SYNC_DELAY-1];
  assign o_VSync = v_dly[SYNC_DELAY-1];
`else
  assign o_HSync = h_sync_n;
  assign o_VSync = v_sync_n;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench for vga_sync_generator; horizontal timing is the real 800-clock line,
// vertical timing is shortened (13 lines) so whole frames fit in a short run.
module tb_vga_sync_generator;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48, HT = HV + HF + HS + HB;
  localparam int VV = 6,   VF = 2,  VS = 2,  VB = 3,  VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef VGA_SYNC_DELAY_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] h_cnt, v_cnt;
  logic       hsync, vsync, visible, line_start, frame_start;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit vis;
    bit ls;
    bit fs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_h = 0;
  int   m_v = 0;
  bit   hs_hist[0:D];
  bit   vs_hist[0:D];

  always #20 clk = ~clk;

  vga_sync_generator #(
    .H_VISIBLE_AREA (HV),
    .H_FRONT_PORCH  (HF),
    .H_SYNC_PULSE   (HS),
    .H_BACK_PORCH   (HB),
    .V_VISIBLE_AREA (VV),
    .V_FRONT_PORCH  (VF),
    .V_SYNC_PULSE   (VS),
    .V_BACK_PORCH   (VB)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .o_H_Counter   (h_cnt),
    .o_V_Counter   (v_cnt),
    .o_HSync       (hsync),
    .o_VSync       (vsync),
    .o_Visible     (visible),
    .o_Line_Start  (line_start),
    .o_Frame_Start (frame_start)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_h"},   int'(h_cnt), 0);
    check({tag, "_v"},   int'(v_cnt), 0);
    check({tag, "_hs"},  int'(hsync), 1);
    check({tag, "_vs"},  int'(vsync), 1);
    check({tag, "_vis"}, int'(visible), 0);
    check({tag, "_ls"},  int'(line_start), 0);
    check({tag, "_fs"},  int'(frame_start), 0);
  endtask

  // Reference raster: region membership derived directly from counter values.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      m_h = 0;
      m_v = 0;
      for (int i = 0; i <= D; i++) begin
        hs_hist[i] = 1'b1;
        vs_hist[i] = 1'b1;
      end
    end else begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
      for (int i = D; i > 0; i--) begin
        hs_hist[i] = hs_hist[i-1];
        vs_hist[i] = vs_hist[i-1];
      end
      hs_hist[0] = !(m_h >= HV + HF && m_h < HV + HF + HS);
      vs_hist[0] = !(m_v >= VV + VF && m_v < VV + VF + VS);
      e.h   = m_h;
      e.v   = m_v;
      e.hs  = hs_hist[D];
      e.vs  = vs_hist[D];
      e.vis = (m_h < HV) && (m_v < VV);
      e.ls  = (m_h == 0);
      e.fs  = (m_h == 0) && (m_v == 0);
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("h_cnt", int'(h_cnt), e.h);
      check("v_cnt", int'(v_cnt), e.v);
      check("hsync", int'(hsync), int'(e.hs));
      check("vsync", int'(vsync), int'(e.vs));
      check("visible", int'(visible), int'(e.vis));
      check("line_start", int'(line_start), int'(e.ls));
      check("frame_start", int'(frame_start), int'(e.fs));
    end
  end

  initial begin
    int k, low_cnt, first_low, first_rise, fs1, fs2, vis_cnt, vs_cnt, ls_cnt;
    bit prev_hs;

    #5 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0;

    low_cnt = 0; first_low = -1; first_rise = -1; prev_hs = 1'b1;
    for (k = 1; k <= HT; k++) begin
      @(negedge clk);
      if (!hsync) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(h_cnt);
      end else if (!prev_hs && first_rise < 0) begin
        first_rise = int'(h_cnt);
      end
      prev_hs = hsync;
    end
    check("hs_low_cycles", low_cnt, HS);
    check("hs_fall_h", first_low, HV + HF + D);
    check("hs_rise_h", first_rise, HV + HF + HS + D);

    fs1 = -1; fs2 = -1; vis_cnt = 0; vs_cnt = 0; ls_cnt = 0;
    for (; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (frame_start) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (fs1 >= 0 && fs2 < 0) begin
        vis_cnt += int'(visible);
        vs_cnt  += int'(!vsync);
        ls_cnt  += int'(line_start);
      end
    end
    check("first_fs_cycle", fs1, FRAME);
    check("fs_spacing", fs2 - fs1, FRAME);
    check("vis_per_frame", vis_cnt, HV * VV);
    check("vs_low_per_frame", vs_cnt, VS * HT);
    check("ls_per_frame", ls_cnt, VT);

    k = 0;
    while (!(h_cnt == 10'd300 && v_cnt == 10'd5) && k < FRAME) begin
      @(negedge clk);
      k++;
    end
    check("reach_300_5", int'(h_cnt == 10'd300 && v_cnt == 10'd5), 1);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    #2 rst = 1'b0;

    @(negedge clk);
    check("rel_h", int'(h_cnt), 1);
    check("rel_v", int'(v_cnt), 0);
    check("rel_vis", int'(visible), 1);
    k = 1; fs1 = -1;
    while (fs1 < 0 && k < FRAME + 10) begin
      @(negedge clk);
      k++;
      if (frame_start) fs1 = k;
    end
    check("fs_after_reset", fs1, FRAME);

    repeat (2) @(negedge clk);
    #1 check("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Generates the 640x480@60 VGA raster timing for the Frogger display path. A free-running horizontal/vertical counter pair drives active-low HSync/VSync, a visible-area flag and frame/line strobes. The counters feed the sprite display stage's H/V counter inputs. The sync outputs go directly to the VGA connector pins.

## Interface
- H_VISIBLE_AREA, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_VISIBLE_AREA, 480, active lines per frame
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- SYNC_DELAY, 2, sync delay in clocks; only used with VGA_SYNC_DELAY_EN

Ports:
- i_Clk  in  1  pixel clock (25 MHz)
- i_Reset  in  1  reset, asynchronous, active-high
- o_H_Counter  out  10  pixel index within line, 0..H_TOTAL-1
- o_V_Counter  out  10  line index within frame, 0..V_TOTAL-1
- o_HSync  out  1  horizontal sync, active low
- o_VSync  out  1  vertical sync, active low
- o_Visible  out  1  high when H < H_VISIBLE_AREA and V < V_VISIBLE_AREA
- o_Line_Start  out  1  one-cycle pulse when H == 0
- o_Frame_Start  out  1  one-cycle pulse when H == 0 and V == 0

## Operation
- H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- H counter increments on every clock edge and wraps from H_TOTAL-1 to 0.
- V counter increments only on the H wrap edge and wraps from V_TOTAL-1 to 0. H and V wrap on the same edge at (799,524) -> (0,0).
- Each axis has a 4-state FSM: S_VISIBLE -> S_FRONT_PORCH -> S_SYNC -> S_BACK_PORCH -> S_VISIBLE.
  - Transitions occur on the edge where the counter enters the first index of the next region.
  - H region starts: 0, 640, 656, 752. V region starts: 0, 480, 490, 492.
- Sync is low exactly while the axis is in S_SYNC: HSync low for H = 656..751, VSync low for V = 490..491.
- All flags are registered and computed from the counter value being loaded on the same edge, so each flag is aligned with the counter value it describes.
- Counter arithmetic is 10-bit unsigned. The wrap compare is equality with TOTAL-1; no overflow path exists.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - Counters reset to 0, both FSMs to S_VISIBLE.
  - o_HSync = 1, o_VSync = 1, o_Visible = 0, o_Line_Start = 0, o_Frame_Start = 0.
- After reset release:
  - The first edge moves the counters to (1,0) with o_Visible = 1.
  - No strobe is emitted for the partial first line or frame.
  - The first o_Line_Start comes at the H wrap; the first o_Frame_Start comes at the (799,524) -> (0,0) wrap.

## Timing
- Latency from counter value to its flags: 0 cycles (same register stage).
- Line period: 800 clocks. Frame period: 420000 clocks.
- o_Line_Start is high for 1 of every 800 cycles. o_Frame_Start is high for 1 of every 420000 cycles.
- o_Visible is high for 307200 cycles per frame.
- The display stage adds 1 register of pixel latency. Sync alignment with pixels is therefore handled by VGA_SYNC_DELAY_EN, not by the counters.

## Configuration
- VGA_SYNC_DELAY_EN defined:
  - o_HSync and o_VSync pass through a SYNC_DELAY-deep shift register, reset to all ones.
  - Sync edges appear SYNC_DELAY clocks after the counter values that cause them.
  - Counters, o_Visible and the strobes are not delayed.
- VGA_SYNC_DELAY_EN undefined: syncs are aligned with the counters and SYNC_DELAY is ignored.

## Structure
- Shared package vga_timing_pkg holds:
  - default timing constants and the derived H_TOTAL/V_TOTAL;
  - the axis state enum {S_VISIBLE, S_FRONT_PORCH, S_SYNC, S_BACK_PORCH}.
- One sub-module, vga_axis_counter, instantiated twice: H with advance tied high, V with advance tied to the H wrap.
  - Inputs: advance, per-axis timing parameters.
  - Outputs: count, state, sync_n, wrap.
- The top level combines the two axes into o_Visible and the strobes, and holds the optional sync delay line.

## Test plan
- Reset release, then count 800 edges -> o_H_Counter sequence 1..799,0; o_V_Counter steps 0 -> 1 on the wrap edge; o_Line_Start high only at H=0.
- Run one full line -> o_HSync low for exactly 96 cycles, first low at H=656, high again at H=752.
- Run one full frame -> o_VSync low for lines 490 and 491 only (1600 clocks); o_Visible high for 307200 cycles.
- Run two frames -> o_Frame_Start pulses exactly 420000 clocks apart, each coinciding with (0,0).
- Assert i_Reset at (300,200) mid-line for 3 cycles -> outputs go to reset values immediately; after release counting restarts at (1,0) with no o_Frame_Start until the next (0,0).
- With VGA_SYNC_DELAY_EN and SYNC_DELAY=2 -> o_HSync falls at H=658 (two clocks after 656) and rises at H=754; counters unchanged.
